// File: rtl/generador_tono.sv
`default_nettype none
// ============================================================================
// Module   : generador_tono
// Brief    : Square-wave tone generator; half-period in prescaled ticks,
//            new half-period word adopted only on a full-period boundary.
// Revision : 1.0
// ============================================================================
module generador_tono #(
    parameter int PRESC = 50,
    parameter int W_PER = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [W_PER-1:0] fre_sel,
    output logic             tono,
    output logic             activo,
    output logic             tick_per,
    output logic             carga
);

    localparam int                 c_pre_w    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PRESC - 1);
    localparam logic [c_pre_w-1:0] c_pre_one  = c_pre_w'(1);
    localparam logic [c_pre_w-1:0] c_pre_zero = '0;
    localparam logic [W_PER-1:0]   c_per_one  = W_PER'(1);
    localparam logic [W_PER-1:0]   c_per_zero = '0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_pre_w-1:0] r_pre_cnt;
    logic [W_PER-1:0]   r_half_cnt;
    logic [W_PER-1:0]   r_per_reg;
    logic               r_tono;
    logic               r_activo;
    logic               r_tick_per;
    logic               r_carga;

    logic w_tick;
    logic w_half_end;
    logic w_sel_zero;

    assign w_tick     = (r_pre_cnt == c_pre_last);
    // r_per_reg is never zero while running, so the subtraction cannot wrap
    assign w_half_end = (r_half_cnt == (r_per_reg - c_per_one));
    assign w_sel_zero = (fre_sel == c_per_zero);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_pre_cnt  <= c_pre_zero;
            r_half_cnt <= c_per_zero;
            r_per_reg  <= c_per_zero;
            r_tono     <= 1'b0;
            r_activo   <= 1'b0;
            r_tick_per <= 1'b0;
            r_carga    <= 1'b0;
        end else begin
            r_tick_per <= 1'b0;
            r_carga    <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_pre_cnt  <= c_pre_zero;
                r_half_cnt <= c_per_zero;
                r_tono     <= 1'b0;
                r_activo   <= 1'b0;
                if (en && !w_sel_zero) begin
                    r_per_reg  <= fre_sel;
                    r_tono     <= 1'b1;
                    r_activo   <= 1'b1;
                    r_tick_per <= 1'b1;
                    r_carga    <= 1'b1;
                    r_state    <= ST_RUN;
                end
            end else if (!en) begin
                // Disable wins over any tick activity in the same cycle
                r_state    <= ST_IDLE;
                r_pre_cnt  <= c_pre_zero;
                r_half_cnt <= c_per_zero;
                r_tono     <= 1'b0;
                r_activo   <= 1'b0;
            end else begin
                r_pre_cnt <= w_tick ? c_pre_zero : (r_pre_cnt + c_pre_one);
                if (w_tick) begin
                    if (!w_half_end) begin
                        r_half_cnt <= r_half_cnt + c_per_one;
                    end else begin
                        r_half_cnt <= c_per_zero;
                        if (r_tono) begin
                            r_tono <= 1'b0;
                        end else if (w_sel_zero) begin
                            r_state   <= ST_IDLE;
                            r_pre_cnt <= c_pre_zero;
                            r_tono    <= 1'b0;
                            r_activo  <= 1'b0;
                        end else begin
                            r_tono     <= 1'b1;
                            r_tick_per <= 1'b1;
                            if (fre_sel != r_per_reg) begin
                                r_per_reg <= fre_sel;
                                r_carga   <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign tono     = r_tono;
    assign activo   = r_activo;
    assign tick_per = r_tick_per;
    assign carga    = r_carga;

endmodule
`default_nettype wire

// File: tb/tb_generador_tono.sv
`default_nettype none
// ============================================================================
// Module   : tb_generador_tono
// Brief    : Directed self-checking bench for generador_tono (PRESC=4 and 1).
// Revision : 1.0
// ============================================================================
module tb_generador_tono;

    logic        clk;
    logic        rst;
    logic        en4;
    logic [10:0] fre4;
    logic        tono4, activo4, tick4, carga4;
    logic        en1;
    logic [10:0] fre1;
    logic        tono1, activo1, tick1, carga1;

    int n_checks = 0;
    int n_fails  = 0;
    int k        = 0;

    generador_tono #(.PRESC(4), .W_PER(11)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .en       (en4),
        .fre_sel  (fre4),
        .tono     (tono4),
        .activo   (activo4),
        .tick_per (tick4),
        .carga    (carga4)
    );

    generador_tono #(.PRESC(1), .W_PER(11)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .en       (en1),
        .fre_sel  (fre1),
        .tono     (tono1),
        .activo   (activo1),
        .tick_per (tick1),
        .carga    (carga1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s (cycle %0d): got %b expected %b", tag, k, obs, exp);
        end
    endtask

    // k indexes the edges since the first IDLE->RUN edge of u_dut4
    task automatic step();
        @(posedge clk);
        #1;
        k = k + 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst  = 1'b0;
        en4  = 1'b1;
        fre4 = 11'd3;
        en1  = 1'b0;
        fre1 = 11'd0;

        // Held in reset despite en=1 and a non-zero frequency
        repeat (5) begin
            @(posedge clk);
            #1;
            check("rst_tono",   tono4,   1'b0);
            check("rst_activo", activo4, 1'b0);
            check("rst_tick",   tick4,   1'b0);
            check("rst_carga",  carga4,  1'b0);
        end
        rst = 1'b1;
        k   = -1;
        step();

        // 12 high / 12 low, period pulse every 24, single load pulse
        while (k < 48) begin
            check("t2_tono",   tono4,   ((k / 12) % 2) == 0);
            check("t2_tick",   tick4,   (k % 24) == 0);
            check("t2_carga",  carga4,  k == 0);
            check("t2_activo", activo4, 1'b1);
            step();
        end

        // Change to 5 during the high phase: adopted at the next rising edge
        check("t3_tono48", tono4,  1'b1);
        check("t3_tick48", tick4,  1'b1);
        check("t3_carg48", carga4, 1'b0);
        step();
        step();
        fre4 = 11'd5;
        while (k < 72) begin
            check("t3_old_tono",  tono4,  k < 60);
            check("t3_old_tick",  tick4,  1'b0);
            check("t3_old_carga", carga4, 1'b0);
            step();
        end
        check("t3_bnd_tono",  tono4,  1'b1);
        check("t3_bnd_tick",  tick4,  1'b1);
        check("t3_bnd_carga", carga4, 1'b1);
        step();
        while (k < 112) begin
            check("t3_new_tono",  tono4,  k < 92);
            check("t3_new_tick",  tick4,  1'b0);
            check("t3_new_carga", carga4, 1'b0);
            step();
        end
        check("t3_end_tono",  tono4,  1'b1);
        check("t3_end_tick",  tick4,  1'b1);
        check("t3_end_carga", carga4, 1'b0);

        // Back to 3, then silence requested mid-low phase
        step();
        fre4 = 11'd3;
        while (k < 152) step();
        check("t4_ld3_carga", carga4, 1'b1);
        check("t4_ld3_tick",  tick4,  1'b1);
        check("t4_ld3_tono",  tono4,  1'b1);
        while (k < 166) step();
        fre4 = 11'd0;
        while (k < 170) step();
        check("t4_low_tono",   tono4,   1'b0);
        check("t4_low_activo", activo4, 1'b1);
        while (k < 176) step();
        check("t4_idle_tono",   tono4,   1'b0);
        check("t4_idle_activo", activo4, 1'b0);
        check("t4_idle_tick",   tick4,   1'b0);
        check("t4_idle_carga",  carga4,  1'b0);
        while (k < 180) step();
        check("t4_stay_tono",   tono4,   1'b0);
        check("t4_stay_activo", activo4, 1'b0);
        fre4 = 11'd2;
        step();
        check("t4_rs_activo", activo4, 1'b1);
        check("t4_rs_carga",  carga4,  1'b1);
        check("t4_rs_tick",   tick4,   1'b1);
        while (k < 190) begin
            check("t4_rs_tono", tono4, k < 189);
            step();
        end

        // PRESC=1, half-period 1: toggles every clock
        check("t5_idle_tono",   tono1,   1'b0);
        check("t5_idle_activo", activo1, 1'b0);
        fre1 = 11'd1;
        en1  = 1'b1;
        step();
        for (int j = 0; j < 8; j++) begin
            check("t5_tono",  tono1,  (j % 2) == 0);
            check("t5_tick",  tick1,  (j % 2) == 0);
            check("t5_carga", carga1, j == 0);
            step();
        end
        en1 = 1'b0;
        step();
        check("t5_dis_tono",   tono1,   1'b0);
        check("t5_dis_activo", activo1, 1'b0);
        check("t5_dis_tick",   tick1,   1'b0);
        en1 = 1'b1;
        step();
        check("t5_en_tono",   tono1,   1'b1);
        check("t5_en_activo", activo1, 1'b1);
        check("t5_en_tick",   tick1,   1'b1);
        check("t5_en_carga",  carga1,  1'b1);

        // Asynchronous reset between edges while the tone is high
        begin
            int w;
            w = 0;
            while (tono4 !== 1'b1 && w < 40) begin
                step();
                w++;
            end
        end
        check("t6_wait_high",   tono4,   1'b1);
        check("t6_pre_activo1", activo1, 1'b1);
        #3;
        rst = 1'b0;
        #1;
        check("t6_tono4",   tono4,   1'b0);
        check("t6_activo4", activo4, 1'b0);
        check("t6_activo1", activo1, 1'b0);
        check("t6_tono1",   tono1,   1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
